// File: rtl/sfp_pkg.sv
// Shared types, default sizes and saturation limits for the psum accumulator block.
// The optional ReLU stage is enabled with the SFP_RELU_EN macro.
package sfp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int LEN_BW  = 4;

    // Limits are returned as 64-bit values so callers can slice them to any lane width up to 63.
    function automatic longint sat_max(int bw);
        return (longint'(1) <<< (bw - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(int bw);
        return -(longint'(1) <<< (bw - 1));
    endfunction

endpackage

// File: rtl/sfp_lane.sv
// One column: signed saturating accumulator with an optional ReLU on the output.
// ReLU is included only when SFP_RELU_EN is defined; it never touches the stored sum.
module sfp_lane
    import sfp_pkg::*;
#(
    parameter int psum_bw = PSUM_BW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_i,
    input  logic                      add_i,
    input  logic signed [psum_bw-1:0] in_i,
    output logic signed [psum_bw-1:0] out_o
);

    localparam longint MAX_L = sat_max(psum_bw);
    localparam longint MIN_L = sat_min(psum_bw);
    localparam logic signed [psum_bw-1:0] MAX_V   = MAX_L[psum_bw-1:0];
    localparam logic signed [psum_bw-1:0] MIN_V   = MIN_L[psum_bw-1:0];
    localparam logic signed [psum_bw:0]   SUM_MAX = MAX_L[psum_bw:0];
    localparam logic signed [psum_bw:0]   SUM_MIN = MIN_L[psum_bw:0];

    logic signed [psum_bw-1:0] acc_q, acc_d;
    logic signed [psum_bw:0]   sum_w;

    // One guard bit is enough to detect overflow of a two-operand signed add.
    assign sum_w = {acc_q[psum_bw-1], acc_q} + {in_i[psum_bw-1], in_i};

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = in_i;
        end else if (add_i) begin
            if (sum_w > SUM_MAX)      acc_d = MAX_V;
            else if (sum_w < SUM_MIN) acc_d = MIN_V;
            else                      acc_d = sum_w[psum_bw-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

`ifdef SFP_RELU_EN
    assign out_o = acc_q[psum_bw-1] ? '0 : acc_q;
`else
    assign out_o = acc_q;
`endif

endmodule

// File: rtl/sfp_acc.sv
// Accumulates acc_len psum vectors per column, then holds the result until the writer takes it.
// Optional per-lane ReLU on out_data is selected by SFP_RELU_EN (see sfp_lane).
module sfp_acc
    import sfp_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int len_bw  = LEN_BW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [col*psum_bw-1:0] in_data,
    input  logic [len_bw-1:0]      acc_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [col*psum_bw-1:0] out_data,
    output logic                   busy
);

    state_t            state_q, state_d;
    logic [len_bw-1:0] cnt_q, cnt_d;
    logic [len_bw-1:0] len_q, len_d;
    logic [len_bw-1:0] eff_len;
    logic [len_bw-1:0] cnt_inc;
    logic              load_w, add_w;

    assign eff_len = (acc_len == '0) ? len_bw'(1) : acc_len;
    assign cnt_inc = cnt_q + len_bw'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        load_w  = 1'b0;
        add_w   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_w  = 1'b1;
                    len_d   = eff_len;
                    cnt_d   = len_bw'(1);
                    state_d = (eff_len == len_bw'(1)) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    add_w   = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == len_q) state_d = HOLD;
                end
            end
            HOLD: begin
                // in_ready is low here, so the cycle that drains the result never takes a vector.
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);

    for (genvar i = 0; i < col; i++) begin : g_lane
        sfp_lane #(.psum_bw(psum_bw)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .load_i (load_w),
            .add_i  (add_w),
            .in_i   (in_data[i*psum_bw +: psum_bw]),
            .out_o  (out_data[i*psum_bw +: psum_bw])
        );
    end

endmodule

// File: tb/tb_sfp_acc.sv
// Directed self-checking bench for sfp_acc with default parameters (16-bit lanes, 8 columns).
// Expectations follow SFP_RELU_EN when the bench is compiled with that macro.
module tb_sfp_acc;

    localparam int PW = 16;
    localparam int NC = 8;
    localparam int LB = 4;
    localparam int W  = PW * NC;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [LB-1:0] acc_len;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    sfp_acc #(.psum_bw(PW), .col(NC), .len_bw(LB)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .acc_len   (acc_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] lane_vec(input int lane, input int val);
        logic [W-1:0] v;
        logic [31:0]  x;
        v = '0;
        x = val;
        v[lane*PW +: PW] = x[PW-1:0];
        return v;
    endfunction

    function automatic logic [W-1:0] all_vec(input int val);
        logic [W-1:0] v;
        logic [31:0]  x;
        x = val;
        for (int i = 0; i < NC; i++) v[i*PW +: PW] = x[PW-1:0];
        return v;
    endfunction

    function automatic int relu(input int v);
`ifdef SFP_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one vector, wait (bounded) for acceptance, then drop in_valid.
    task automatic send(input string tag, input logic [W-1:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_timeout"}, W'(n < 20), W'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp_v;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        acc_len   = '0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy",      W'(busy),      W'(0));
        check("rst_out_data",  out_data,      '0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_in_ready", W'(in_ready), W'(1));

        // Length 1: result appears the cycle after the only transfer.
        acc_len = 4'd1;
        send("len1", all_vec(5));
        check("len1_out_valid", W'(out_valid), W'(1));
        check("len1_data",      out_data,      all_vec(5));
        check("len1_in_ready",  W'(in_ready),  W'(0));
        check("len1_busy",      W'(busy),      W'(1));
        drain();
        check("len1_busy_after",  W'(busy),      W'(0));
        check("len1_valid_after", W'(out_valid), W'(0));
        check("len1_ready_after", W'(in_ready),  W'(1));

        // Length 9, lane0 = 1..9 back-to-back; acc_len change after latching is ignored.
        acc_len  = 4'd9;
        in_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            in_data = lane_vec(0, i);
            tick();
            if (i == 1) acc_len = 4'd2;
            if (i == 8) check("len9_not_early", W'(out_valid), W'(0));
        end
        check("len9_out_valid", W'(out_valid), W'(1));
        check("len9_data",      out_data,      lane_vec(0, 45));
        in_data = lane_vec(0, 100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("len9_hold_in_ready", W'(in_ready), W'(0));
            check("len9_hold_data",     out_data,     lane_vec(0, 45));
        end
        in_valid = 1'b0;
        drain();
        check("len9_idle", W'(busy), W'(0));

        // Positive and negative saturation on lane3.
        acc_len = 4'd2;
        send("satp_a", lane_vec(3, 32000));
        send("satp_b", lane_vec(3, 1000));
        check("sat_pos", out_data, lane_vec(3, 32767));
        drain();
        send("satn_a", lane_vec(3, -32768));
        send("satn_b", lane_vec(3, -5));
        check("sat_neg", out_data, lane_vec(3, relu(-32768)));
        drain();

        // After clamping, an opposite-sign input adds from the clamped value.
        acc_len = 4'd3;
        send("satr_a", lane_vec(3, 32000));
        send("satr_b", lane_vec(3, 1000));
        send("satr_c", lane_vec(3, -767));
        check("sat_recover", out_data, lane_vec(3, 32000));
        drain();

        // Mixed-sign lanes, idle gaps inside ACC, and a long out_ready stall.
        acc_len = 4'd3;
        send("mix_a", lane_vec(1, -3) | lane_vec(2, 2));
        for (int i = 0; i < 3; i++) tick();
        check("mix_wait_busy",  W'(busy),      W'(1));
        check("mix_wait_valid", W'(out_valid), W'(0));
        send("mix_b", lane_vec(1, -2) | lane_vec(2, 2));
        send("mix_c", lane_vec(1, -2) | lane_vec(2, 3));
        exp_v = lane_vec(1, relu(-7)) | lane_vec(2, 7);
        for (int i = 0; i < 10; i++) begin
            check("mix_stable", out_data, exp_v);
            tick();
        end
        check("mix_valid_stall", W'(out_valid), W'(1));
        drain();

        // Reset mid-accumulation discards the partial sum.
        acc_len = 4'd4;
        send("rst_a", lane_vec(0, 100));
        send("rst_b", lane_vec(0, 100));
        #3;
        reset = 1'b1;
        #1;
        check("midrst_valid", W'(out_valid), W'(0));
        check("midrst_busy",  W'(busy),      W'(0));
        check("midrst_data",  out_data,      '0);
        tick();
        reset = 1'b0;
        #1;
        acc_len = 4'd1;
        send("post_rst", lane_vec(0, 3));
        check("post_rst_data", out_data, lane_vec(0, 3));
        drain();

        // acc_len 0 behaves as length 1.
        acc_len = 4'd0;
        send("len0", lane_vec(0, 11));
        check("len0_valid", W'(out_valid), W'(1));
        check("len0_data",  out_data,      lane_vec(0, 11));
        drain();
        check("len0_idle", W'(busy), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfp_acc.md
SFP_ACC -- requirements
Module: sfp_acc

Interface
REQ-001 Parameter: psum_bw, default 16, signed width of one column partial sum.
REQ-002 Parameter: col, default 8, number of array columns (lanes).
REQ-003 Parameter: len_bw, default 4, width of the accumulation-length input.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream output-FIFO vector available.
REQ-007 in_ready  output  1  block accepts a vector this cycle.
REQ-008 in_data  input  col*psum_bw  signed psums, column 0 in LSBs.
REQ-009 acc_len  input  len_bw  vectors summed per output (0 treated as 1).
REQ-010 out_valid  output  1  result vector held on out_data.
REQ-011 out_ready  input  1  downstream psum SRAM writer accepts the result.
REQ-012 out_data  output  col*psum_bw  post-processed result, column 0 in LSBs.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Transfer in: in_valid and in_ready both high at a rising edge; transfer out: out_valid and out_ready both high.
REQ-015 FSM states: IDLE, ACC, HOLD.
REQ-016 IDLE: in_ready=1; on transfer in, the lane accumulators load in_data, acc_len is latched (0 -> 1), and the count is set to 1.
REQ-017 IDLE to HOLD when latched length is 1, else IDLE to ACC.
REQ-018 ACC: in_ready=1; each transfer in adds in_data to the lane accumulators and increments the count.
REQ-019 ACC to HOLD on the transfer that makes count equal the latched length.
REQ-020 acc_len changes after latching are ignored until the next IDLE.
REQ-021 HOLD: in_ready=0 and out_valid=1; out_data stays stable until out_ready.
REQ-022 HOLD to IDLE on transfer out; a new vector is not accepted in that same cycle.
REQ-023 Latency: out_valid rises the cycle after the last input transfer.
REQ-024 Each lane add saturates to [-2^(psum_bw-1), 2^(psum_bw-1)-1]; once a lane is saturated, later opposite-sign inputs still add from the clamped value.
REQ-025 With in_valid low in ACC, the block waits indefinitely and state is held.

Reset
REQ-026 On reset assertion, asynchronously: state=IDLE, count=0, all accumulators=0, out_valid=0, busy=0, out_data=0.
REQ-027 After reset deassertion, in_ready=1 in the first cycle.
REQ-028 Reset mid-ACC or mid-HOLD discards the partial result, with no out_valid pulse.

Configuration
REQ-029 Macro SFP_RELU_EN defined: each out_data lane that is negative outputs 0.
REQ-030 Macro SFP_RELU_EN undefined: out_data is the saturated signed sum unchanged.
REQ-031 The SFP_RELU_EN setting has no effect on the accumulator contents, FSM, or timing.

Structure
REQ-032 Package sfp_pkg holds: the state enum (IDLE/ACC/HOLD), the default PSUM_BW, COL and LEN_BW values, and the saturation limit functions.
REQ-033 Sub-module sfp_lane holds one column's accumulator, saturating adder and optional ReLU; sfp_acc instantiates col copies plus the FSM and counter.

Verification
REQ-034 acc_len=1, in_data all lanes=5 -> out_valid next cycle, all lanes 5, busy falls after out_ready.
REQ-035 acc_len=9, lane0 inputs 1..9 back-to-back -> lane0=45 exactly one cycle after the 9th transfer; in_ready=0 until out_ready.
REQ-036 acc_len=2, lane3 inputs 32000 and 1000 -> lane3=32767 (saturated); lane3 inputs -32768 and -5 -> -32768, or 0 with SFP_RELU_EN.
REQ-037 acc_len=3, sums lane1=-7, lane2=+7, out_ready held low 10 cycles -> out_data stable; lane1 reads 0 with SFP_RELU_EN and -7 without.
REQ-038 Reset asserted after 2 of 4 vectors, then acc_len=1 with input 3 -> the output is 3, with no stale contribution.
REQ-039 acc_len=0, one vector of 11 -> treated as length 1, output 11.
